// File: rtl/request_frame_parser.sv
// Front-end for the sensor decoder: turns 2-byte UART frames (address, command) into
// one-shot decoder requests, runs monitoring sessions until a stop frame, and bounds every wait.
module request_frame_parser #(
  parameter int BYTE_TIMEOUT = 5_000_000,
  parameter int DONE_TIMEOUT = 10_000_000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        decoder_finished_i,
  output logic        enable_o,
  output logic [31:0] device_selector_o,
  output logic [7:0]  request_o,
  output logic        busy_o,
  output logic        frame_error_o,
  output logic        decoder_timeout_o
);

  // state      | meaning
  // WAIT_ADDR  | idle, expecting byte0 (device address)
  // WAIT_CMD   | address latched, expecting byte1 (command)
  // ISSUE      | one cycle: present selector/request and pulse enable
  // WAIT_DONE  | one-shot request outstanding, waiting for decoder_finished
  // STREAM     | monitoring session active, expecting stop frame address
  // STREAM_CMD | stop frame address seen, expecting 0x07/0x08
  // STOP_WAIT  | stop forwarded, waiting for decoder_finished
  localparam logic [2:0] WAIT_ADDR  = 3'd0;
  localparam logic [2:0] WAIT_CMD   = 3'd1;
  localparam logic [2:0] ISSUE      = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] STREAM     = 3'd4;
  localparam logic [2:0] STREAM_CMD = 3'd5;
  localparam logic [2:0] STOP_WAIT  = 3'd6;

  localparam int TMAX = (BYTE_TIMEOUT > DONE_TIMEOUT) ? BYTE_TIMEOUT : DONE_TIMEOUT;
  localparam int TW   = ($clog2(TMAX) > 24) ? $clog2(TMAX) : 24;
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          enable_q, enable_d;
  logic [31:0]   sel_q, sel_d;
  logic [7:0]    req_q, req_d;
  logic          ferr_q, ferr_d;
  logic          dto_q, dto_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    enable_d = 1'b0;
    sel_d    = sel_q;
    req_d    = req_q;
    ferr_d   = 1'b0;
    dto_d    = 1'b0;

    case (state_q)
      WAIT_ADDR: begin
        timer_d = '0;
        if (rx_valid_i) begin
          if (rx_data_i <= 8'h1F) begin
            addr_d  = rx_data_i[4:0];
            state_d = WAIT_CMD;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      WAIT_CMD: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid_i) begin
          if (rx_data_i <= 8'h06) begin
            cmd_d   = rx_data_i;
            state_d = ISSUE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_ADDR;
          end
        end else if (timer_q == BYTE_LAST) begin
          ferr_d  = 1'b1;
          state_d = WAIT_ADDR;
        end
      end
      ISSUE: begin
        enable_d = 1'b1;
        sel_d    = 32'd1 << addr_q;
        req_d    = cmd_q;
        state_d  = (cmd_q >= 8'h05) ? STREAM : WAIT_DONE;
      end
      WAIT_DONE, STOP_WAIT: begin
        if (decoder_finished_i) begin
          sel_d   = '0;
          req_d   = 8'h00;
          ferr_d  = rx_valid_i;
          state_d = WAIT_ADDR;
        end else if (timer_q == DONE_LAST) begin
          // Timeout owns this cycle so the two error pulses never overlap.
          dto_d   = 1'b1;
          sel_d   = '0;
          req_d   = 8'h00;
          state_d = WAIT_ADDR;
        end else begin
          ferr_d = rx_valid_i;
        end
      end
      STREAM: begin
        timer_d = '0;
        if (rx_valid_i) begin
          if (rx_data_i == {3'b000, addr_q}) begin
            state_d = STREAM_CMD;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      STREAM_CMD: begin
        if (rx_valid_i) begin
          if (rx_data_i == 8'h07 || rx_data_i == 8'h08) begin
            req_d   = rx_data_i;
            state_d = STOP_WAIT;
          end else begin
            ferr_d  = 1'b1;
            state_d = STREAM;
          end
        end else if (timer_q == BYTE_LAST) begin
          ferr_d  = 1'b1;
          state_d = STREAM;
        end
      end
      default: begin
        sel_d   = '0;
        req_d   = 8'h00;
        state_d = WAIT_ADDR;
      end
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= WAIT_ADDR;
      timer_q  <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      enable_q <= 1'b0;
      sel_q    <= '0;
      req_q    <= '0;
      ferr_q   <= 1'b0;
      dto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      enable_q <= enable_d;
      sel_q    <= sel_d;
      req_q    <= req_d;
      ferr_q   <= ferr_d;
      dto_q    <= dto_d;
    end
  end

  assign enable_o          = enable_q;
  assign device_selector_o = sel_q;
  assign request_o         = req_q;
  assign busy_o            = (state_q != WAIT_ADDR);
  assign frame_error_o     = ferr_q;
  assign decoder_timeout_o = dto_q;

endmodule

// File: tb/tb_request_frame_parser.sv
// Directed, table-driven bench for request_frame_parser using short timeouts
// (BYTE_TIMEOUT=100, DONE_TIMEOUT=200); each vector is one clock of inputs plus expected outputs.
module tb_request_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fin;
  logic        enable;
  logic [31:0] sel;
  logic [7:0]  req;
  logic        busy;
  logic        ferr;
  logic        dto;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic        fin;
    int          rep;
    logic        en;
    logic [31:0] sel;
    logic [7:0]  req;
    logic        busy;
    logic        ferr;
    logic        dto;
  } vec_t;

  vec_t tbl[$];

  request_frame_parser #(.BYTE_TIMEOUT(100), .DONE_TIMEOUT(200)) dut (
    .clock_i(clk), .reset_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .decoder_finished_i(fin), .enable_o(enable), .device_selector_o(sel),
    .request_o(req), .busy_o(busy), .frame_error_o(ferr), .decoder_timeout_o(dto)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [7:0] d, logic f, int rep, logic en,
                              logic [31:0] s, logic [7:0] r, logic b, logic fe, logic dt);
    vec_t x;
    x.vld = v; x.data = d; x.fin = f; x.rep = rep; x.en = en;
    x.sel = s; x.req = r; x.busy = b; x.ferr = fe; x.dto = dt;
    return x;
  endfunction

  task automatic check(string tag, vec_t v);
    vectors++;
    if (enable !== v.en || sel !== v.sel || req !== v.req || busy !== v.busy ||
        ferr !== v.ferr || dto !== v.dto) begin
      miscompares++;
      $display("FAIL %s: got en=%0b sel=%h req=%h busy=%0b ferr=%0b dto=%0b, want en=%0b sel=%h req=%h busy=%0b ferr=%0b dto=%0b",
               tag, enable, sel, req, busy, ferr, dto, v.en, v.sel, v.req, v.busy, v.ferr, v.dto);
    end
  endtask

  task automatic apply(string tag, vec_t v);
    for (int r = 0; r < v.rep; r++) begin
      @(negedge clk);
      rx_valid = v.vld;
      rx_data  = v.data;
      fin      = v.fin;
      @(posedge clk);
      #1;
      check($sformatf("%s#%0d", tag, r), v);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; fin = 1'b0;

    // one-shot frame 0x00,0x01 then finished
    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 1, 32'h1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 19, 0, 32'h1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1,  1, 0, 32'h0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h0, 8'h00, 0, 0, 0));
    // monitoring session on device 3 with stray bytes, stop-command timeout, stop 0x07
    tbl.push_back(mk(1, 8'h03, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 1, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  5, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1,  1, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(1, 8'h04, 0,  1, 0, 32'h8, 8'h05, 1, 1, 0));
    tbl.push_back(mk(1, 8'h03, 0,  1, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 99, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h8, 8'h05, 1, 1, 0));
    tbl.push_back(mk(1, 8'h03, 0,  1, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0,  1, 0, 32'h8, 8'h05, 1, 1, 0));
    tbl.push_back(mk(1, 8'h03, 0,  1, 0, 32'h8, 8'h05, 1, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0,  1, 0, 32'h8, 8'h07, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  3, 0, 32'h8, 8'h07, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0,  1, 0, 32'h8, 8'h07, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1,  1, 0, 32'h0, 8'h00, 0, 0, 0));
    // malformed frames and address/command boundaries
    tbl.push_back(mk(1, 8'h25, 0,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h09, 0,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 8'h02, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 8'h20, 0,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 8'h1F, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h06, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 1, 32'h8000_0000, 8'h06, 1, 0, 0));
    tbl.push_back(mk(1, 8'h1F, 0,  1, 0, 32'h8000_0000, 8'h06, 1, 0, 0));
    tbl.push_back(mk(1, 8'h08, 0,  1, 0, 32'h8000_0000, 8'h08, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1,  1, 0, 32'h0, 8'h00, 0, 0, 0));
    // byte timeout, then byte landing exactly on the expiry cycle
    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 99, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 99, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 1, 32'h1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 1,  1, 0, 32'h0, 8'h00, 0, 1, 0));
    // decoder timeout with a dropped byte in WAIT_DONE
    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0,  1, 0, 32'h0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 1, 32'h1, 8'h02, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0,  1, 0, 32'h1, 8'h02, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0,198, 0, 32'h1, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 32'h0, 8'h00, 0, 0, 0));

    repeat (3) @(negedge clk);
    check("reset", mk(0, 8'h00, 0, 1, 0, 32'h0, 8'h00, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // asynchronous reset in the middle of a monitoring session
    apply("rst_a", mk(1, 8'h01, 0, 1, 0, 32'h0, 8'h00, 1, 0, 0));
    apply("rst_b", mk(1, 8'h05, 0, 1, 0, 32'h0, 8'h00, 1, 0, 0));
    apply("rst_c", mk(0, 8'h00, 0, 1, 1, 32'h2, 8'h05, 1, 0, 0));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", mk(0, 8'h00, 0, 1, 0, 32'h0, 8'h00, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    apply("post_a", mk(1, 8'h01, 0, 1, 0, 32'h0, 8'h00, 1, 0, 0));
    apply("post_b", mk(1, 8'h04, 0, 1, 0, 32'h0, 8'h00, 1, 0, 0));
    apply("post_c", mk(0, 8'h00, 0, 1, 1, 32'h2, 8'h04, 1, 0, 0));
    apply("post_d", mk(0, 8'h00, 1, 1, 0, 32'h0, 8'h00, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
